branch_resolve_ctrl: RTL and testbench



---
 rtl/branch_resolve_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - conditional branch resolver sharing the ALU subtractor
module branch_resolve_ctrl #(
  parameter int ALU_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [2:0]  br_op,
  input  logic [31:0] br_rs,
  input  logic [31:0] br_rt,
  input  logic [31:0] br_pc,
  input  logic [15:0] br_imm,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic        alu_done,
  input  logic [1:0]  cmp_flags,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_taken,
  output logic [31:0] res_target,
  output logic        res_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLTZ = 3'b010;
  localparam logic [2:0] OP_BGEZ = 3'b011;
  localparam logic [2:0] OP_BLEZ = 3'b100;
  localparam logic [2:0] OP_BGTZ = 3'b101;

  // Last counter value before the REQ+WAIT budget is exhausted.
  localparam logic [7:0] TO_LAST = 8'(ALU_TIMEOUT - 1);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [2:0]  op_q;
  logic [31:0] pc_q;
  logic [15:0] imm_q;

  logic        br_ready_n, alu_req_n, res_valid_n, res_taken_n, res_err_n;
  logic [31:0] alu_a_n, alu_b_n, res_target_n;

  logic        accept;
  logic        op_legal;
  logic        cond_taken;
  logic        timeout_hit;
  logic [31:0] pc_plus4;
  logic [31:0] pc_branch;

  // Flush blocks acceptance even though br_ready is a registered output.
  assign accept      = br_valid & br_ready & ~flush;
  assign op_legal    = (br_op != 3'b110) && (br_op != 3'b111);
  assign timeout_hit = (cnt == TO_LAST);
  assign pc_plus4    = pc_q + 32'd4;
  assign pc_branch   = pc_plus4 + {{14{imm_q[15]}}, imm_q, 2'b00};

  // Classify comparator flags against the latched opcode.
  always_comb begin
    cond_taken = 1'b0;
    case (op_q)
      OP_BEQ:  cond_taken = (cmp_flags == 2'b01);
      OP_BNE:  cond_taken = cmp_flags[1];
      OP_BLTZ: cond_taken = (cmp_flags == 2'b10);
      OP_BGEZ: cond_taken = cmp_flags[0];
      OP_BLEZ: cond_taken = (cmp_flags == 2'b10) || (cmp_flags == 2'b01);
      OP_BGTZ: cond_taken = (cmp_flags == 2'b11);
      default: cond_taken = 1'b0;
    endcase
  end

  // Next-state and next registered output values.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    br_ready_n   = 1'b0;
    alu_req_n    = alu_req;
    alu_a_n      = alu_a;
    alu_b_n      = alu_b;
    res_valid_n  = res_valid;
    res_taken_n  = res_taken;
    res_target_n = res_target;
    res_err_n    = res_err;

    if (flush) begin
      state_n     = IDLE;
      cnt_n       = 8'd0;
      alu_req_n   = 1'b0;
      res_valid_n = 1'b0;
      br_ready_n  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          br_ready_n = 1'b1;
          if (accept) begin
            br_ready_n = 1'b0;
            if (op_legal) begin
              state_n   = REQ;
              cnt_n     = 8'd0;
              alu_req_n = 1'b1;
              alu_a_n   = br_rs;
              alu_b_n   = (br_op == OP_BEQ || br_op == OP_BNE) ? br_rt : 32'd0;
            end else begin
              state_n      = RESP;
              res_valid_n  = 1'b1;
              res_taken_n  = 1'b0;
              res_err_n    = 1'b1;
              res_target_n = br_pc + 32'd4;
            end
          end
        end
        REQ: begin
          cnt_n = cnt + 8'd1;
          // Timeout wins over a late grant so the budget is never exceeded.
          if (timeout_hit) begin
            state_n      = RESP;
            alu_req_n    = 1'b0;
            res_valid_n  = 1'b1;
            res_taken_n  = 1'b0;
            res_err_n    = 1'b1;
            res_target_n = pc_plus4;
          end else if (alu_gnt) begin
            state_n   = WAIT;
            alu_req_n = 1'b0;
          end
        end
        WAIT: begin
          cnt_n = cnt + 8'd1;
          if (alu_done) begin
            state_n      = RESP;
            res_valid_n  = 1'b1;
            res_err_n    = (cmp_flags == 2'b00);
            res_taken_n  = (cmp_flags != 2'b00) && cond_taken;
            res_target_n = ((cmp_flags != 2'b00) && cond_taken) ? pc_branch : pc_plus4;
          end else if (timeout_hit) begin
            state_n      = RESP;
            res_valid_n  = 1'b1;
            res_taken_n  = 1'b0;
            res_err_n    = 1'b1;
            res_target_n = pc_plus4;
          end
        end
        RESP: begin
          if (res_ready) begin
            state_n     = IDLE;
            res_valid_n = 1'b0;
            br_ready_n  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      br_ready   <= 1'b0;
      alu_req    <= 1'b0;
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
      res_valid  <= 1'b0;
      res_taken  <= 1'b0;
      res_target <= 32'd0;
      res_err    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      br_ready   <= br_ready_n;
      alu_req    <= alu_req_n;
      alu_a      <= alu_a_n;
      alu_b      <= alu_b_n;
      res_valid  <= res_valid_n;
      res_taken  <= res_taken_n;
      res_target <= res_target_n;
      res_err    <= res_err_n;
    end
  end

  // Branch context captured at acceptance for flag classification and targets.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= 3'd0;
      pc_q  <= 32'd0;
      imm_q <= 16'd0;
    end else if (accept) begin
      op_q  <= br_op;
      pc_q  <= br_pc;
      imm_q <= br_imm;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - directed scoreboard bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        reset, flush, br_valid, br_ready;
  logic [2:0]  br_op;
  logic [31:0] br_rs, br_rt, br_pc;
  logic [15:0] br_imm;
  logic        alu_req, alu_gnt, alu_done;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  cmp_flags;
  logic        res_valid, res_ready, res_taken, res_err;
  logic [31:0] res_target;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  branch_resolve_ctrl #(.ALU_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .br_valid(br_valid), .br_ready(br_ready), .br_op(br_op),
    .br_rs(br_rs), .br_rt(br_rt), .br_pc(br_pc), .br_imm(br_imm),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .cmp_flags(cmp_flags),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_target(res_target), .res_err(res_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one branch for a single accept cycle; expectation goes to the scoreboard.
  task automatic send(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [31:0] pc, input logic [15:0] imm,
                      input logic push, input logic et, input logic [31:0] etgt, input logic ee);
    exp_t e;
    chk("br_ready_before_send", {31'd0, br_ready}, 32'd1);
    br_valid = 1'b1; br_op = op; br_rs = rs; br_rt = rt; br_pc = pc; br_imm = imm;
    if (push) begin
      e.taken = et; e.target = etgt; e.err = ee;
      sb.push_back(e);
    end
    tick();
    br_valid = 1'b0;
  endtask

  // Pop the oldest expectation, compare the presented result, then complete the handshake.
  task automatic collect(input string tag);
    exp_t e;
    chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd1);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_taken"},  {31'd0, res_taken}, {31'd0, e.taken});
      chk({tag, "_target"}, res_target, e.target);
      chk({tag, "_err"},    {31'd0, res_err}, {31'd0, e.err});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_br_ready_back"}, {31'd0, br_ready}, 32'd1);
  endtask

  // Full legal branch with immediate grant and done: checks minimum latency and operands.
  task automatic run_branch(input string tag, input logic [2:0] op, input logic [31:0] rs,
                            input logic [31:0] rt, input logic [31:0] pc, input logic [15:0] imm,
                            input logic [1:0] flags, input logic [31:0] exp_b,
                            input logic et, input logic [31:0] etgt, input logic ee);
    send(op, rs, rt, pc, imm, 1'b1, et, etgt, ee);
    chk({tag, "_alu_req"}, {31'd0, alu_req}, 32'd1);
    chk({tag, "_alu_a"}, alu_a, rs);
    chk({tag, "_alu_b"}, alu_b, exp_b);
    chk({tag, "_res_early"}, {31'd0, res_valid}, 32'd0);
    alu_gnt = 1'b1;
    tick();
    alu_gnt = 1'b0;
    chk({tag, "_req_drop"}, {31'd0, alu_req}, 32'd0);
    alu_done = 1'b1; cmp_flags = flags;
    tick();
    alu_done = 1'b0; cmp_flags = 2'b00;
    collect(tag);
  endtask

  initial begin
    int n;
    logic        st_taken, st_err;
    logic [31:0] st_tgt;
    reset = 1'b1; flush = 1'b0; br_valid = 1'b0; br_op = 3'd0;
    br_rs = 32'd0; br_rt = 32'd0; br_pc = 32'd0; br_imm = 16'd0;
    alu_gnt = 1'b0; alu_done = 1'b0; cmp_flags = 2'b00; res_ready = 1'b0;
    tick();
    tick();
    chk("rst_br_ready", {31'd0, br_ready}, 32'd0);
    chk("rst_alu_req", {31'd0, alu_req}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_target", res_target, 32'd0);
    chk("rst_res_err", {31'd0, res_err}, 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_br_ready", {31'd0, br_ready}, 32'd1);

    run_branch("beq", 3'b000, 32'h5, 32'h5, 32'h0040_0000, 16'h0004, 2'b01, 32'h5,
               1'b1, 32'h0040_0014, 1'b0);
    run_branch("bgtz_neg", 3'b101, 32'hFFFF_FFFF, 32'h1234, 32'h0040_0100, 16'hFFFF, 2'b10, 32'h0,
               1'b0, 32'h0040_0104, 1'b0);
    run_branch("bgtz_pos", 3'b101, 32'hFFFF_FFFF, 32'h1234, 32'h0040_0100, 16'hFFFF, 2'b11, 32'h0,
               1'b1, 32'h0040_0100, 1'b0);
    run_branch("bne", 3'b001, 32'h1, 32'h2, 32'h0000_1000, 16'h0010, 2'b10, 32'h2,
               1'b1, 32'h0000_1044, 1'b0);
    run_branch("blez_pos", 3'b100, 32'h7, 32'h0, 32'h0000_2000, 16'h0003, 2'b11, 32'h0,
               1'b0, 32'h0000_2004, 1'b0);
    run_branch("bgez_badflags", 3'b011, 32'h7, 32'h0, 32'h0000_3000, 16'h0003, 2'b00, 32'h0,
               1'b0, 32'h0000_3004, 1'b1);

    send(3'b110, 32'h1, 32'h2, 32'h0000_4000, 16'h0008, 1'b1, 1'b0, 32'h0000_4004, 1'b1);
    chk("illegal_alu_req", {31'd0, alu_req}, 32'd0);
    collect("illegal");

    send(3'b001, 32'h1, 32'h2, 32'h0000_5000, 16'h0008, 1'b1, 1'b0, 32'h0000_5004, 1'b1);
    n = 0;
    while (alu_req && n < 40) begin
      n++;
      tick();
    end
    chk("timeout_req_cycles", n, 32'd15);
    collect("timeout");

    send(3'b000, 32'h3, 32'h3, 32'h0000_6000, 16'h0001, 1'b0, 1'b0, 32'h0, 1'b0);
    alu_gnt = 1'b1;
    tick();
    alu_gnt = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_br_ready", {31'd0, br_ready}, 32'd1);
    alu_done = 1'b1; cmp_flags = 2'b01;
    tick();
    alu_done = 1'b0; cmp_flags = 2'b00;
    for (int i = 0; i < 3; i++) begin
      chk("flush_no_res", {31'd0, res_valid}, 32'd0);
      tick();
    end

    send(3'b111, 32'h0, 32'h0, 32'h0000_7000, 16'h0000, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("pre_reset_resp", {31'd0, res_valid}, 32'd1);
    reset = 1'b1;
    tick();
    chk("resp_rst_valid", {31'd0, res_valid}, 32'd0);
    chk("resp_rst_err", {31'd0, res_err}, 32'd0);
    chk("resp_rst_target", res_target, 32'd0);
    chk("resp_rst_br_ready", {31'd0, br_ready}, 32'd0);
    reset = 1'b0;
    tick();
    chk("resp_rst_recover", {31'd0, br_ready}, 32'd1);

    send(3'b010, 32'h8000_0000, 32'h0, 32'hFFFF_FFFC, 16'h0000, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
    alu_gnt = 1'b1;
    tick();
    alu_gnt = 1'b0;
    alu_done = 1'b1; cmp_flags = 2'b10;
    tick();
    alu_done = 1'b0; cmp_flags = 2'b00;
    st_taken = res_taken; st_tgt = res_target; st_err = res_err;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_taken", {31'd0, res_taken}, {31'd0, st_taken});
      chk("hold_target", res_target, st_tgt);
      chk("hold_err", {31'd0, res_err}, {31'd0, st_err});
      chk("hold_br_ready", {31'd0, br_ready}, 32'd0);
      tick();
    end
    collect("wrap");

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
